// File: rtl/core_pkg.sv
// Core-wide types and constants shared by the execute/writeback slice.
// Holds the physical tag type, the writeback request record and source indices.
package core_pkg;

    localparam int XLEN  = 32;
    localparam int PREGS = 64;
    localparam int TAG_W = $clog2(PREGS);

    typedef logic [TAG_W-1:0] preg_tag_t;

    typedef struct packed {
        preg_tag_t       tag;
        logic [XLEN-1:0] data;
    } wb_req_t;

    localparam int WB_SRCS = 4;

    typedef enum logic [1:0] {
        SRC_ALU0 = 2'd0,
        SRC_ALU1 = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_BRU  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small pointer-based circular FIFO for one writeback source.
// Head entry is visible combinationally; clr_i empties it without touching storage.
module wb_fifo
    import core_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_req_t
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  entry_t                     wdata_i,
    input  logic                       pop_i,
    output entry_t                     rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: buffers per-source results and drives the two registered
// PRF write ports (also the wakeup broadcast) with round-robin, tag-distinct grants.
module prf_wb_arbiter #(
    parameter int XLEN       = core_pkg::XLEN,
    parameter int PREGS      = core_pkg::PREGS,
    parameter int NUM_SRC    = core_pkg::WB_SRCS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic [NUM_SRC-1:0]                src_valid,
    output logic [NUM_SRC-1:0]                src_ready,
    input  logic [$clog2(PREGS)-1:0]          src_tag   [NUM_SRC],
    input  logic [XLEN-1:0]                   src_data  [NUM_SRC],
    output logic                              wen0,
    output logic [$clog2(PREGS)-1:0]          wtag0,
    output logic [XLEN-1:0]                   wdata0,
    output logic                              wen1,
    output logic [$clog2(PREGS)-1:0]          wtag1,
    output logic [XLEN-1:0]                   wdata1,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy [NUM_SRC]
);

    localparam int TAG_W = $clog2(PREGS);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } req_t;

    req_t               wr_req [NUM_SRC];
    req_t               head   [NUM_SRC];
    logic [NUM_SRC-1:0] full, empty, push, pop;

    logic               started_q;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               gnt_a_vld, gnt_b_vld;
    logic [IDX_W-1:0]   gnt_a_idx, gnt_b_idx, scan_idx;

    logic               wen0_q, wen1_q;
    logic [TAG_W-1:0]   wtag0_q, wtag1_q;
    logic [XLEN-1:0]    wdata0_q, wdata1_q;

    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return IDX_W'(s);
    endfunction

    // Holds ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) started_q <= 1'b0;
        else          started_q <= 1'b1;
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_ready[g] = started_q & ~full[g] & ~flush;
        assign push[g]      = src_valid[g] & src_ready[g];
        assign wr_req[g]    = '{tag: src_tag[g], data: src_data[g]};

        wb_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (req_t)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .clr_i   (flush),
            .push_i  (push[g]),
            .wdata_i (wr_req[g]),
            .pop_i   (pop[g]),
            .rdata_o (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .count_o (occupancy[g])
        );
    end

    // Grant B must differ in tag from grant A so both ports never write the same register.
    always_comb begin
        gnt_a_vld = 1'b0;
        gnt_a_idx = '0;
        gnt_b_vld = 1'b0;
        gnt_b_idx = '0;
        scan_idx  = '0;
        pop       = '0;
        rr_d      = rr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = idx_add(rr_q, k);
            if (!flush && !empty[scan_idx]) begin
                if (!gnt_a_vld) begin
                    gnt_a_vld = 1'b1;
                    gnt_a_idx = scan_idx;
                end else if (!gnt_b_vld && (head[scan_idx].tag != head[gnt_a_idx].tag)) begin
                    gnt_b_vld = 1'b1;
                    gnt_b_idx = scan_idx;
                end
            end
        end
        if (gnt_a_vld) pop[gnt_a_idx] = 1'b1;
        if (gnt_b_vld) pop[gnt_b_idx] = 1'b1;
        if (gnt_b_vld)      rr_d = idx_add(gnt_b_idx, 1);
        else if (gnt_a_vld) rr_d = idx_add(gnt_a_idx, 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q     <= '0;
            wen0_q   <= 1'b0;
            wen1_q   <= 1'b0;
            wtag0_q  <= '0;
            wtag1_q  <= '0;
            wdata0_q <= '0;
            wdata1_q <= '0;
        end else begin
            rr_q   <= rr_d;
            wen0_q <= gnt_a_vld;
            wen1_q <= gnt_b_vld;
            if (gnt_a_vld) begin
                wtag0_q  <= head[gnt_a_idx].tag;
                wdata0_q <= head[gnt_a_idx].data;
            end
            if (gnt_b_vld) begin
                wtag1_q  <= head[gnt_b_idx].tag;
                wdata1_q <= head[gnt_b_idx].data;
            end
        end
    end

    assign wen0   = wen0_q;
    assign wtag0  = wtag0_q;
    assign wdata0 = wdata0_q;
    assign wen1   = wen1_q;
    assign wtag1  = wtag1_q;
    assign wdata1 = wdata1_q;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Bench for prf_wb_arbiter: directed vector table, hand sequences and random
// traffic, all checked against a queue-based reference model.
module tb_prf_wb_arbiter;

    localparam int NS    = 4;
    localparam int DEPTH = 2;
    localparam int XL    = 32;
    localparam int TW    = 6;
    localparam int CW    = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [TW-1:0]     src_tag  [NS];
    logic [XL-1:0]     src_data [NS];
    logic              wen0, wen1;
    logic [TW-1:0]     wtag0, wtag1;
    logic [XL-1:0]     wdata0, wdata1;
    logic [CW-1:0]     occupancy [NS];

    always #5 clk = ~clk;

    prf_wb_arbiter #(
        .XLEN(XL), .PREGS(64), .NUM_SRC(NS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_data(src_data),
        .wen0(wen0), .wtag0(wtag0), .wdata0(wdata0),
        .wen1(wen1), .wtag1(wtag1), .wdata1(wdata1),
        .occupancy(occupancy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [TW-1:0] tag;
        logic [XL-1:0] data;
    } ent_t;

    ent_t mq [NS][$];
    int   m_rr;

    task automatic model_clear(input bit clr_rr);
        for (int i = 0; i < NS; i++) mq[i].delete();
        if (clr_rr) m_rr = 0;
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic step(output logic [NS-1:0] acc);
        int   a, b, idx;
        ent_t ea, eb;
        ent_t inc [NS];
        logic [NS-1:0] rdy;
        #1;
        for (int i = 0; i < NS; i++) begin
            rdy[i] = !flush && (mq[i].size() < DEPTH);
            inc[i] = '{tag: src_tag[i], data: src_data[i]};
        end
        check("src_ready", 64'(src_ready), 64'(rdy));
        acc = src_valid & rdy;
        a = -1; b = -1; ea = '0; eb = '0;
        if (!flush) begin
            for (int k = 0; k < NS; k++) begin
                idx = (m_rr + k) % NS;
                if (mq[idx].size() != 0) begin
                    if (a < 0) a = idx;
                    else if (b < 0 && mq[idx][0].tag != mq[a][0].tag) b = idx;
                end
            end
        end
        if (a >= 0) ea = mq[a][0];
        if (b >= 0) eb = mq[b][0];
        @(posedge clk);
        if (flush) begin
            model_clear(1'b0);
        end else begin
            if (a >= 0) void'(mq[a].pop_front());
            if (b >= 0) void'(mq[b].pop_front());
            for (int i = 0; i < NS; i++) if (acc[i]) mq[i].push_back(inc[i]);
            if (a >= 0) m_rr = ((b >= 0 ? b : a) + 1) % NS;
        end
        #1;
        check("wen0", 64'(wen0), 64'(a >= 0));
        check("wen1", 64'(wen1), 64'(b >= 0));
        if (a >= 0) begin
            check("wtag0", 64'(wtag0), 64'(ea.tag));
            check("wdata0", 64'(wdata0), 64'(ea.data));
        end
        if (b >= 0) begin
            check("wtag1", 64'(wtag1), 64'(eb.tag));
            check("wdata1", 64'(wdata1), 64'(eb.data));
        end
        if (wen0 && wen1) check("tag_distinct", 64'(wtag0 == wtag1), 64'(0));
        for (int i = 0; i < NS; i++) check("occupancy", 64'(occupancy[i]), 64'(mq[i].size()));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        src_valid = '0;
        #1;
        check("rst_wen0", 64'(wen0), 64'(0));
        check("rst_wen1", 64'(wen1), 64'(0));
        check("rst_wtag0", 64'(wtag0), 64'(0));
        check("rst_wdata1", 64'(wdata1), 64'(0));
        check("rst_ready", 64'(src_ready), 64'(0));
        for (int i = 0; i < NS; i++) check("rst_occ", 64'(occupancy[i]), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(src_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("ready_after_edge", 64'(src_ready), 64'hF);
        model_clear(1'b1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic                 fl;
        logic [NS-1:0]        v;
        logic [NS*TW-1:0]     t;
        logic [NS*XL-1:0]     d;
        logic                 ew0;
        logic [TW-1:0]        et0;
        logic [XL-1:0]        ed0;
        logic                 ew1;
        logic [TW-1:0]        et1;
        logic [XL-1:0]        ed1;
        logic [NS*CW-1:0]     occ;
    } vec_t;

    localparam int NVEC = 13;
    vec_t tbl [NVEC];

    function automatic vec_t row(input logic fl, input logic [NS-1:0] v,
                                 input logic [NS*TW-1:0] t, input logic [NS*XL-1:0] d,
                                 input logic ew0, input logic [TW-1:0] et0, input logic [XL-1:0] ed0,
                                 input logic ew1, input logic [TW-1:0] et1, input logic [XL-1:0] ed1,
                                 input logic [NS*CW-1:0] occ);
        vec_t r;
        r = '{fl: fl, v: v, t: t, d: d, ew0: ew0, et0: et0, ed0: ed0,
              ew1: ew1, et1: et1, ed1: ed1, occ: occ};
        return r;
    endfunction

    localparam logic [NS*TW-1:0] T0 = '0;
    localparam logic [NS*XL-1:0] D0 = '0;

    initial begin
        logic [NS-1:0] acc;
        int n0, cyc;
        bit saw_full;

        for (int i = 0; i < NS; i++) begin
            src_tag[i]  = '0;
            src_data[i] = '0;
        end
        reset_n   = 1'b1;
        flush     = 1'b0;
        src_valid = '0;

        // all four sources at once, tags 1..4, rr starts at 0
        tbl[0]  = row(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {32'hA4, 32'hA3, 32'hA2, 32'hA1},
                      0, 0, 0, 0, 0, 0, {2'd1, 2'd1, 2'd1, 2'd1});
        tbl[1]  = row(0, 4'b0000, T0, D0, 1, 6'd1, 32'hA1, 1, 6'd2, 32'hA2, {2'd1, 2'd1, 2'd0, 2'd0});
        tbl[2]  = row(0, 4'b0000, T0, D0, 1, 6'd3, 32'hA3, 1, 6'd4, 32'hA4, 8'h00);
        tbl[3]  = row(0, 4'b0000, T0, D0, 0, 0, 0, 0, 0, 0, 8'h00);
        // src1 and src3 share tag 9, rr back at 0
        tbl[4]  = row(0, 4'b1010, {6'd9, 6'd0, 6'd9, 6'd0}, {32'hB3, 32'h0, 32'hB1, 32'h0},
                      0, 0, 0, 0, 0, 0, {2'd1, 2'd0, 2'd1, 2'd0});
        tbl[5]  = row(0, 4'b0000, T0, D0, 1, 6'd9, 32'hB1, 0, 0, 0, {2'd1, 2'd0, 2'd0, 2'd0});
        tbl[6]  = row(0, 4'b0000, T0, D0, 1, 6'd9, 32'hB3, 0, 0, 0, 8'h00);
        tbl[7]  = row(0, 4'b0000, T0, D0, 0, 0, 0, 0, 0, 0, 8'h00);
        // single transfer, two-edge latency
        tbl[8]  = row(0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                      0, 0, 0, 0, 0, 0, {2'd0, 2'd0, 2'd0, 2'd1});
        tbl[9]  = row(0, 4'b0000, T0, D0, 1, 6'd5, 32'hDEADBEEF, 0, 0, 0, 8'h00);
        // three entries buffered, then flush with a src3 valid that must be dropped
        tbl[10] = row(0, 4'b0111, {6'd0, 6'd7, 6'd7, 6'd7}, {32'h0, 32'hC2, 32'hC1, 32'hC0},
                      0, 0, 0, 0, 0, 0, {2'd0, 2'd1, 2'd1, 2'd1});
        tbl[11] = row(1, 4'b1000, {6'd8, 6'd0, 6'd0, 6'd0}, {32'hC3, 32'h0, 32'h0, 32'h0},
                      0, 0, 0, 0, 0, 0, 8'h00);
        tbl[12] = row(0, 4'b0000, T0, D0, 0, 0, 0, 0, 0, 0, 8'h00);

        @(negedge clk);
        do_reset();

        for (int r = 0; r < NVEC; r++) begin
            flush     = tbl[r].fl;
            src_valid = tbl[r].v;
            for (int i = 0; i < NS; i++) begin
                src_tag[i]  = tbl[r].t[i*TW +: TW];
                src_data[i] = tbl[r].d[i*XL +: XL];
            end
            if (tbl[r].fl) begin
                #1;
                check("vec_flush_ready", 64'(src_ready), 64'(0));
                @(negedge clk);
                flush = tbl[r].fl;
                #0;
                // the #1 above consumed part of the cycle; re-align to a fresh negedge
            end
            step(acc);
            check("vec_wen0", 64'(wen0), 64'(tbl[r].ew0));
            check("vec_wen1", 64'(wen1), 64'(tbl[r].ew1));
            if (tbl[r].ew0) begin
                check("vec_wtag0", 64'(wtag0), 64'(tbl[r].et0));
                check("vec_wdata0", 64'(wdata0), 64'(tbl[r].ed0));
            end
            if (tbl[r].ew1) begin
                check("vec_wtag1", 64'(wtag1), 64'(tbl[r].et1));
                check("vec_wdata1", 64'(wdata1), 64'(tbl[r].ed1));
            end
            for (int i = 0; i < NS; i++)
                check("vec_occ", 64'(occupancy[i]), 64'(tbl[r].occ[i*CW +: CW]));
        end
        flush     = 1'b0;
        src_valid = '0;

        // src2 streams alone: one write per cycle, never more than one entry buffered
        for (int k = 0; k < 12; k++) begin
            src_valid  = 4'b0100;
            src_tag[2] = TW'(k + 10);
            src_data[2] = $urandom;
            step(acc);
            check("stream_acc", 64'(acc[2]), 64'(1));
            check("stream_ready", 64'(src_ready[2]), 64'(1));
            check("stream_occ_le1", 64'(occupancy[2] <= 1), 64'(1));
            if (k > 0) check("stream_wen0", 64'(wen0), 64'(1));
        end
        src_valid = '0;
        step(acc);

        // every source loaded with the same tag: one grant per cycle, src0 backs up
        n0 = 0; cyc = 0; saw_full = 0;
        for (int i = 0; i < NS; i++) begin
            src_tag[i]  = 6'd7;
            src_data[i] = $urandom;
        end
        src_valid = 4'b1111;
        while (n0 < 3 && cyc < 40) begin
            step(acc);
            cyc++;
            if (occupancy[0] == 2 && src_ready[0] == 1'b0) saw_full = 1;
            for (int i = 0; i < NS; i++) if (acc[i]) src_data[i] = $urandom;
            if (acc[0]) n0++;
        end
        check("full_src0_seen", 64'(saw_full), 64'(1));
        check("third_src0_accepted", 64'(n0 >= 3), 64'(1));
        src_valid = '0;
        repeat (10) step(acc);

        // randomized traffic with occasional flush and one mid-run reset
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                do_reset();
                src_valid = '0;
            end
            flush = ($urandom_range(0, 99) < 3);
            for (int i = 0; i < NS; i++) begin
                if (!src_valid[i] && $urandom_range(0, 99) < 60) begin
                    src_valid[i] = 1'b1;
                    src_tag[i]   = TW'($urandom_range(0, 7));
                    src_data[i]  = $urandom;
                end
            end
            step(acc);
            src_valid = src_valid & ~acc;
        end
        flush     = 1'b0;
        src_valid = '0;
        repeat (6) step(acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
